// File: rtl/fpu_ctrl_pkg.sv
// Shared types and constants for the FPU add/sub
// front-end scheduler.
package fpu_ctrl_pkg;

  localparam int FP_W = 32;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RDN = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin arbiter;
// ptr names the port that wins a tie.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic pick;

  always_comb begin
    pick   = req[ptr] ? ptr : ~ptr;
    gnt_id = pick;
    gnt    = '0;
    if (|req) begin
      gnt = 2'b01 << pick;
    end
  end

endmodule

// File: rtl/fpu_addsub_sched.sv
// Schedules one shared FP add/sub unit between
// two requesters; one operation in flight.
module fpu_addsub_sched
  import fpu_ctrl_pkg::*;
#(
  parameter int FU_LAT = 2,
  parameter int W      = FP_W
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [1:0][W-1:0] req_a,
  input  logic [1:0][W-1:0] req_b,
  input  logic [1:0]      req_op,
  input  logic [1:0][1:0] req_rm,
  output logic [1:0]      rsp_valid,
  input  logic [1:0]      rsp_ready,
  output logic [W-1:0]    rsp_result,
  output logic            rsp_error,
  output logic            rsp_overflow,
  output logic [W-1:0]    fu_a,
  output logic [W-1:0]    fu_b,
  output logic            fu_op,
  output logic [1:0]      fu_rm,
  input  logic [W-1:0]    fu_result,
  input  logic            fu_error,
  input  logic            fu_overflow
);

  localparam int CW =
    (FU_LAT > 1) ? $clog2(FU_LAT) : 1;

  state_t        state;
  state_t        stateNext;
  logic          rrPtr;
  logic          owner;
  logic [CW-1:0] cnt;
  logic [1:0]    gnt;
  logic          gntId;
  logic          accept;
  logic          capture;
  logic          rspDone;

  rr_arb2 uArb (
    .req    (req_valid),
    .ptr    (rrPtr),
    .gnt    (gnt),
    .gnt_id (gntId)
  );

  always_comb begin
    stateNext = state;
    req_ready = '0;
    accept    = 1'b0;
    capture   = 1'b0;
    rspDone   = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = gnt;
        if (|req_valid) begin
          accept    = 1'b1;
          stateNext = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          stateNext = RESP;
        end
      end
      RESP: begin
        if (rsp_ready[owner]) begin
          rspDone   = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      rrPtr <= 1'b0;
      owner <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      if (accept) begin
        owner <= gntId;
        rrPtr <= ~gntId;
        cnt   <= CW'(FU_LAT - 1);
      end else if (state == WAIT && !capture) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Operands stay frozen until the next grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fu_a  <= '0;
      fu_b  <= '0;
      fu_op <= 1'b0;
      fu_rm <= '0;
    end else if (accept) begin
      fu_a  <= req_a[gntId];
      fu_b  <= req_b[gntId];
      fu_op <= req_op[gntId];
      fu_rm <= req_rm[gntId];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid    <= '0;
      rsp_result   <= '0;
      rsp_error    <= 1'b0;
      rsp_overflow <= 1'b0;
    end else if (capture) begin
      rsp_valid    <= 2'b01 << owner;
      rsp_result   <= fu_result;
      rsp_error    <= fu_error;
      rsp_overflow <= fu_overflow;
    end else if (rspDone) begin
      rsp_valid <= '0;
    end
  end

endmodule
